// File: rtl/lsu_byte_sequencer.sv
// Serialises one load/store into little-endian byte accesses with range/encoding fault checks.
// Latency nbytes+1 cycles to resp_valid (fault: 1 cycle); no queueing, req_ready only in IDLE.
module lsu_byte_sequencer #(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_t       state;
  logic         is_write;
  logic         sext;
  logic [3:0]   nbytes;
  logic [2:0]   idx;
  logic [55:0]  wdata_sh;
  logic [63:0]  asm_q;
  logic [63:0]  asm_next;
  logic [3:0]   req_nbytes;
  logic [ADDR_W:0] req_end;
  logic         req_fault;
  logic         last_byte;

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [3:0] nb,
                                         input logic sx);
    case (nb)
      4'd1:    return {{56{sx & d[7]}},  d[7:0]};
      4'd2:    return {{48{sx & d[15]}}, d[15:0]};
      4'd4:    return {{32{sx & d[31]}}, d[31:0]};
      default: return d;
    endcase
  endfunction

  assign req_ready = (state == IDLE) && !reset;

  // The extra top bit keeps addr+nbytes from wrapping past the range check.
  always_comb begin
    req_nbytes = 4'd1 << req_funct3[1:0];
    req_end    = {1'b0, req_addr} + (ADDR_W+1)'(req_nbytes);
    req_fault  = (req_funct3 == 3'b111) || (req_write && req_funct3[2]) ||
                 (req_end > MEM_LIMIT);
    last_byte  = ({1'b0, idx} == (nbytes - 4'd1));
    asm_next   = asm_q;
    asm_next[{idx, 3'b000} +: 8] = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      is_write   <= 1'b0;
      sext       <= 1'b0;
      nbytes     <= 4'd0;
      idx        <= 3'd0;
      wdata_sh   <= '0;
      asm_q      <= '0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            is_write   <= req_write;
            nbytes     <= req_nbytes;
            sext       <= ~req_funct3[2];
            idx        <= 3'd0;
            asm_q      <= '0;
            resp_rdata <= '0;
            if (req_fault) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              state      <= RESP;
            end else begin
              mem_addr   <= req_addr;
              mem_wdata  <= req_wdata[7:0];
              wdata_sh   <= req_wdata[63:8];
              mem_we     <= req_write;
              mem_re     <= ~req_write;
              resp_fault <= 1'b0;
              state      <= XFER;
            end
          end
        end
        XFER: begin
          if (!is_write) asm_q <= asm_next;
          if (last_byte) begin
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= is_write ? 64'd0 : extend(asm_next, nbytes, sext);
            state      <= RESP;
          end else begin
            idx       <= idx + 3'd1;
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= wdata_sh[7:0];
            wdata_sh  <= wdata_sh >> 8;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
